pc_fetch_stage: RTL and testbench
=================================

# pc_fetch_stage

Instruction-fetch stage of the five-stage pipeline: owns the program counter, drives the instruction-memory address, computes the sequential PC+4, and registers the fetched instruction with its PC+4 into the IF/ID pipeline register. The IF/ID PC+4 value travels down the pipeline and becomes the PC+4 input of the branch-target adder. That adder's target returns here together with the branch decision to redirect fetch.

## Interface
- RESET_PC, 32'h0000_0000, fetch address after reset; word-aligned.
- Clk  in  1  rising-edge clock for all state.
- Rst_n  in  1  asynchronous, active-low reset.
- Stall  in  1  from hazard unit; holds PC and IF/ID.
- BranchTaken  in  1  branch resolved taken (older instruction, later stage).
- BranchTarget  in  32  branch-target adder result.
- Jump  in  1  jump decoded in ID.
- JumpTarget  in  32  jump destination.
- Instruction  in  32  instruction-memory read data for address PC (combinational read).
- PC  out  32  current fetch address (registered).
- IFID_Instruction  out  32  registered instruction to ID.
- IFID_PCAddResult  out  32  registered PC+4 of that instruction.
- IFID_Valid  out  1  IF/ID holds a real instruction.
- AlignErr  out  1  one-cycle pulse: redirect target had nonzero bits [1:0].
- FetchCount  out  32  count of instructions latched valid into IF/ID.

## Operation
- Next-PC priority, evaluated each cycle: BranchTaken > Jump > Stall > sequential.
  - BranchTaken: PC <= {BranchTarget[31:2],2'b00}.
  - else Jump: PC <= {JumpTarget[31:2],2'b00}.
  - else Stall: PC holds.
  - else: PC <= PC+4.
- PC+4 is a 32-bit modulo add; 32'hFFFF_FFFC + 4 = 32'h0000_0000, no flag.
- IF/ID update:
  - Redirect (BranchTaken or Jump): load a bubble; IFID_Instruction <= 32'h0000_0000 (NOP), IFID_PCAddResult <= 0, IFID_Valid <= 0. Redirect overrides Stall.
  - else Stall: all IF/ID fields hold.
  - else: IFID_Instruction <= Instruction, IFID_PCAddResult <= PC+4, IFID_Valid <= 1.
- AlignErr: registered. Set to 1 for exactly the cycle after a redirect whose selected target had bits [1:0] != 0; otherwise 0. The target is still truncated and used.
- FetchCount: increments by 1 on each edge that loads IF/ID with Valid=1. Wraps 32'hFFFF_FFFF -> 0.
- Flushing ID/EX on a branch is out of scope; it is owned by the hazard unit.

## Timing
- Reset (Rst_n low, asynchronous): PC = RESET_PC, IFID_Instruction = 0, IFID_PCAddResult = 0, IFID_Valid = 0, AlignErr = 0, FetchCount = 0. All outputs hold these values while Rst_n is low.
- Reset mid-operation: takes effect immediately regardless of Clk; any pending redirect is discarded.
- After reset release, the first rising edge latches the instruction at RESET_PC into IF/ID: IFID_Valid=1, IFID_PCAddResult = RESET_PC+4.
- Fetch latency: an instruction at address A appears on the IF/ID outputs 1 cycle after PC=A with no stall.
- Redirect penalty: 1 bubble at IF/ID. The target instruction is in IF/ID 2 edges after the redirect cycle.
- Stall: 0-cycle response. The edge during which Stall=1 changes no PC or IF/ID state; the stage resumes on the first edge with Stall=0.
- Simultaneous BranchTaken and Jump: the branch target wins, and the jump is lost. This is correct, because the jump is on the wrong path.

## Test plan
- Reset then run (RESET_PC=0x0, memory returns 0x1111_0000 | addr):
  - PC sequence 0,4,8,C.
  - IF/ID shows 0x1111_0000/0x4, then 0x1111_0004/0x8.
  - FetchCount 1,2,3.
- Stall for 3 cycles at PC=0x8:
  - PC holds 0x8.
  - IF/ID holds 0x1111_0004/0x8.
  - FetchCount holds.
  - On release, PC advances to 0xC.
- BranchTaken=1 with BranchTarget=0x40 while Stall=1 and Jump=1 (JumpTarget=0x80):
  - Next PC=0x40.
  - IFID_Valid=0, instruction 0.
  - The following edge gives IF/ID 0x1111_0040/0x44.
- Jump to 0x102:
  - PC=0x100.
  - AlignErr=1 for exactly one cycle.
  - Bubble inserted.
- Wrap cases:
  - PC=0xFFFF_FFFC, no stall: next PC=0x0, and IFID_PCAddResult=0x0.
  - FetchCount preset by run-length to 0xFFFF_FFFF: next valid fetch gives 0.
- Assert Rst_n low between clock edges during a redirect: all outputs go to reset values immediately, and PC=RESET_PC on release.

Source files
------------

// File: rtl/pc_fetch_stage_if.sv
// Fetch-stage bus: redirect/stall controls and instruction-memory data in,
// program counter and IF/ID pipeline register out.
interface pc_fetch_stage_if;
    logic        Stall;
    logic        BranchTaken;
    logic [31:0] BranchTarget;
    logic        Jump;
    logic [31:0] JumpTarget;
    logic [31:0] Instruction;
    logic [31:0] PC;
    logic [31:0] IFID_Instruction;
    logic [31:0] IFID_PCAddResult;
    logic        IFID_Valid;
    logic        AlignErr;
    logic [31:0] FetchCount;

    // master: pipeline control and instruction memory; slave: the fetch stage
    modport master (
        output Stall, BranchTaken, BranchTarget, Jump, JumpTarget, Instruction,
        input  PC, IFID_Instruction, IFID_PCAddResult, IFID_Valid, AlignErr, FetchCount
    );

    modport slave (
        input  Stall, BranchTaken, BranchTarget, Jump, JumpTarget, Instruction,
        output PC, IFID_Instruction, IFID_PCAddResult, IFID_Valid, AlignErr, FetchCount
    );
endinterface

// File: rtl/pc_fetch_stage.sv
// Instruction-fetch stage: program counter with branch/jump redirect and stall,
// IF/ID pipeline register, misaligned-target flag and valid-fetch counter.
module pc_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input logic             Clk,
    input logic             Rst_n,
    pc_fetch_stage_if.slave bus
);

    logic [31:0] pcQ, pcD;
    logic [31:0] ifidInstrQ, ifidInstrD;
    logic [31:0] ifidPc4Q, ifidPc4D;
    logic        ifidValidQ, ifidValidD;
    logic        alignErrQ, alignErrD;
    logic [31:0] fetchCountQ, fetchCountD;

    logic [31:0] pcPlus4;
    logic        redirect;
    logic [31:0] rawTarget;
    logic        loadValid;

    always_comb begin
        pcPlus4   = pcQ + 32'd4;
        redirect  = bus.BranchTaken | bus.Jump;
        // An older branch outranks a jump still sitting on its wrong path.
        rawTarget = bus.BranchTaken ? bus.BranchTarget : bus.JumpTarget;
        loadValid = !redirect && !bus.Stall;
    end

    always_comb begin
        pcD         = pcQ;
        ifidInstrD  = ifidInstrQ;
        ifidPc4D    = ifidPc4Q;
        ifidValidD  = ifidValidQ;
        fetchCountD = fetchCountQ;
        alignErrD   = redirect && (rawTarget[1:0] != 2'b00);
        if (redirect) begin
            pcD        = {rawTarget[31:2], 2'b00};
            ifidInstrD = 32'h0000_0000;
            ifidPc4D   = 32'h0000_0000;
            ifidValidD = 1'b0;
        end else if (!bus.Stall) begin
            pcD         = pcPlus4;
            ifidInstrD  = bus.Instruction;
            ifidPc4D    = pcPlus4;
            ifidValidD  = 1'b1;
        end
        if (loadValid) begin
            fetchCountD = fetchCountQ + 32'd1;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            pcQ         <= RESET_PC;
            ifidInstrQ  <= 32'h0000_0000;
            ifidPc4Q    <= 32'h0000_0000;
            ifidValidQ  <= 1'b0;
            alignErrQ   <= 1'b0;
            fetchCountQ <= 32'h0000_0000;
        end else begin
            pcQ         <= pcD;
            ifidInstrQ  <= ifidInstrD;
            ifidPc4Q    <= ifidPc4D;
            ifidValidQ  <= ifidValidD;
            alignErrQ   <= alignErrD;
            fetchCountQ <= fetchCountD;
        end
    end

    assign bus.PC               = pcQ;
    assign bus.IFID_Instruction = ifidInstrQ;
    assign bus.IFID_PCAddResult = ifidPc4Q;
    assign bus.IFID_Valid       = ifidValidQ;
    assign bus.AlignErr         = alignErrQ;
    assign bus.FetchCount       = fetchCountQ;

endmodule

// File: tb/tb_pc_fetch_stage.sv
// Scoreboard bench for pc_fetch_stage: a reference model pushes expected state
// per driven cycle, popped and compared one edge later.
module tb_pc_fetch_stage;

    logic Clk;
    logic Rst_n;

    pc_fetch_stage_if bus ();

    pc_fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .bus   (bus)
    );

    // Instruction memory: combinational read tagging each word with its address.
    assign bus.Instruction = 32'h1111_0000 | bus.PC;

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
        logic [31:0] pc4;
        logic        valid;
        logic        align;
        logic [31:0] cnt;
    } exp_t;

    exp_t sb[$];

    int nVectors = 0;
    int nMiscompares = 0;

    logic [31:0] mPc, mIns, mPc4, mCnt;
    logic        mValid, mAlign;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nVectors++;
        if (got !== exp) begin
            nMiscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic resetModel();
        mPc    = 32'h0000_0000;
        mIns   = 32'h0;
        mPc4   = 32'h0;
        mValid = 1'b0;
        mAlign = 1'b0;
        mCnt   = 32'h0;
        sb.delete();
    endtask

    task automatic checkReset(input string tag);
        check({tag, "_pc"},    bus.PC, 32'h0);
        check({tag, "_ins"},   bus.IFID_Instruction, 32'h0);
        check({tag, "_pc4"},   bus.IFID_PCAddResult, 32'h0);
        check({tag, "_valid"}, {31'b0, bus.IFID_Valid}, 32'h0);
        check({tag, "_align"}, {31'b0, bus.AlignErr}, 32'h0);
        check({tag, "_cnt"},   bus.FetchCount, 32'h0);
    endtask

    // Drive one cycle of controls, push the model's prediction, clock, pop and compare.
    task automatic cycle(input string tag, input logic st, input logic bt,
                         input logic [31:0] btT, input logic jp, input logic [31:0] jpT);
        exp_t e;
        logic redir;
        logic [31:0] tgt, pc4;
        bus.Stall        = st;
        bus.BranchTaken  = bt;
        bus.BranchTarget = btT;
        bus.Jump         = jp;
        bus.JumpTarget   = jpT;

        redir = bt | jp;
        tgt   = bt ? btT : jpT;
        pc4   = mPc + 32'd4;
        mAlign = redir && (tgt[1:0] != 2'b00);
        if (redir) begin
            mPc    = {tgt[31:2], 2'b00};
            mIns   = 32'h0;
            mPc4   = 32'h0;
            mValid = 1'b0;
        end else if (!st) begin
            mIns   = 32'h1111_0000 | mPc;
            mPc4   = pc4;
            mValid = 1'b1;
            mPc    = pc4;
            mCnt   = mCnt + 32'd1;
        end
        e.pc = mPc; e.ins = mIns; e.pc4 = mPc4;
        e.valid = mValid; e.align = mAlign; e.cnt = mCnt;
        sb.push_back(e);

        @(posedge Clk);
        #1;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'h1, 32'h0);
        end else begin
            e = sb.pop_front();
            check({tag, "_pc"},    bus.PC, e.pc);
            check({tag, "_ins"},   bus.IFID_Instruction, e.ins);
            check({tag, "_pc4"},   bus.IFID_PCAddResult, e.pc4);
            check({tag, "_valid"}, {31'b0, bus.IFID_Valid}, {31'b0, e.valid});
            check({tag, "_align"}, {31'b0, bus.AlignErr}, {31'b0, e.align});
            check({tag, "_cnt"},   bus.FetchCount, e.cnt);
        end
    endtask

    task automatic run(input string tag);
        cycle(tag, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        Rst_n            = 1'b0;
        bus.Stall        = 1'b0;
        bus.BranchTaken  = 1'b0;
        bus.BranchTarget = 32'h0;
        bus.Jump         = 1'b0;
        bus.JumpTarget   = 32'h0;
        resetModel();

        #12;
        checkReset("rst");
        Rst_n = 1'b1;
        #1;
        check("pc_after_release", bus.PC, 32'h0);

        // Sequential run: PC 4, 8 and IF/ID tracking the fetched words.
        run("seq0");
        check("seq0_ifid_ins_const", bus.IFID_Instruction, 32'h1111_0000);
        check("seq0_ifid_pc4_const", bus.IFID_PCAddResult, 32'h4);
        run("seq1");
        check("seq1_pc_const", bus.PC, 32'h8);
        check("seq1_ifid_ins_const", bus.IFID_Instruction, 32'h1111_0004);

        // Three stalled cycles at PC=8, then release.
        for (int i = 0; i < 3; i++) cycle($sformatf("stall%0d", i), 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        check("stall_pc_const", bus.PC, 32'h8);
        check("stall_cnt_const", bus.FetchCount, 32'd2);
        run("unstall");
        check("unstall_pc_const", bus.PC, 32'hC);
        check("unstall_cnt_const", bus.FetchCount, 32'd3);

        // Branch beats both Jump and Stall.
        cycle("br_all", 1'b1, 1'b1, 32'h40, 1'b1, 32'h80);
        check("br_all_pc_const", bus.PC, 32'h40);
        check("br_all_valid_const", {31'b0, bus.IFID_Valid}, 32'h0);
        run("br_after");
        check("br_after_ins_const", bus.IFID_Instruction, 32'h1111_0040);
        check("br_after_pc4_const", bus.IFID_PCAddResult, 32'h44);

        // Misaligned jump: truncated target, one-cycle AlignErr.
        cycle("jmp_mis", 1'b0, 1'b0, 32'h0, 1'b1, 32'h102);
        check("jmp_mis_pc_const", bus.PC, 32'h100);
        check("jmp_mis_align_const", {31'b0, bus.AlignErr}, 32'h1);
        run("jmp_mis_after");
        check("jmp_mis_after_align_const", {31'b0, bus.AlignErr}, 32'h0);

        // Only the selected target's low bits matter for AlignErr.
        cycle("br_ok_jmp_bad", 1'b0, 1'b1, 32'h200, 1'b1, 32'h303);
        cycle("br_bad_jmp_ok", 1'b0, 1'b1, 32'h401, 1'b1, 32'h500);
        cycle("jmp_stall", 1'b1, 1'b0, 32'h0, 1'b1, 32'h600);

        // PC wrap at the top of the address space.
        cycle("jmp_top", 1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC);
        run("wrap");
        check("wrap_pc_const", bus.PC, 32'h0);
        check("wrap_pc4_const", bus.IFID_PCAddResult, 32'h0);
        run("post_wrap");

        // Randomised control mix.
        for (int i = 0; i < 40; i++) begin
            logic st, bt, jp;
            logic [31:0] bT, jT;
            st = ($urandom_range(0, 3) == 0);
            bt = ($urandom_range(0, 7) == 0);
            jp = ($urandom_range(0, 7) == 0);
            bT = $urandom;
            jT = $urandom;
            cycle($sformatf("rnd%0d", i), st, bt, bT, jp, jT);
        end

        // Reset asserted mid-cycle while a redirect is pending.
        bus.Stall        = 1'b0;
        bus.Jump         = 1'b0;
        bus.BranchTaken  = 1'b1;
        bus.BranchTarget = 32'h0000_0800;
        #3;
        Rst_n = 1'b0;
        #1;
        checkReset("midrst");
        @(posedge Clk);
        #1;
        checkReset("midrst_hold");
        bus.BranchTaken = 1'b0;
        #2;
        Rst_n = 1'b1;
        #1;
        check("midrst_release_pc", bus.PC, 32'h0);
        resetModel();
        run("after_rst0");
        check("after_rst0_pc_const", bus.PC, 32'h4);
        check("after_rst0_cnt_const", bus.FetchCount, 32'd1);
        run("after_rst1");

        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule
